// File: rtl/updown_counter_ctl_if.sv
// Control and status bundle for updown_counter_ctl.
// The master drives the count controls; the slave (the counter) returns value and flags.
interface updown_counter_ctl_if #(
  parameter int WIDTH = 8
);
  logic                    en;
  logic [1:0]              mode;
  logic                    sat;
  logic                    ld;
  logic signed [WIDTH-1:0] ld_val;
  logic signed [WIDTH-1:0] val;
  logic                    dir;
  logic                    wrap;
  logic                    at_max;
  logic                    at_min;

  modport master (
    output en, mode, sat, ld, ld_val,
    input  val, dir, wrap, at_max, at_min
  );

  modport slave (
    input  en, mode, sat, ld, ld_val,
    output val, dir, wrap, at_max, at_min
  );
endinterface

// File: rtl/updown_counter_ctl.sv
// Signed up/down counter with programmable bounds, parallel load, saturate/wrap
// select and a bounce mode whose direction is held in a two-state FSM.
module updown_counter_ctl #(
  parameter int WIDTH   = 8,
  parameter int MIN_VAL = -128,
  parameter int MAX_VAL = 127,
  parameter int RST_VAL = 0
) (
  input logic                clk,
  input logic                rst,
  updown_counter_ctl_if.slave bus
);

  typedef enum logic {
    DN = 1'b0,
    UP = 1'b1
  } dir_t;

  localparam logic signed [WIDTH:0]   MIN_X = (WIDTH+1)'(MIN_VAL);
  localparam logic signed [WIDTH:0]   MAX_X = (WIDTH+1)'(MAX_VAL);
  localparam logic signed [WIDTH:0]   ONE_X = (WIDTH+1)'(1);
  localparam logic signed [WIDTH-1:0] MIN_W = WIDTH'(MIN_VAL);
  localparam logic signed [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
  localparam logic signed [WIDTH-1:0] RST_W = WIDTH'(RST_VAL);

  localparam logic [1:0] MODE_DOWN   = 2'b00;
  localparam logic [1:0] MODE_UP     = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;

  logic signed [WIDTH-1:0] val_q;
  dir_t                    dir_q;
  logic                    wrap_q;

  logic signed [WIDTH:0]   cur_x;
  logic signed [WIDTH:0]   ld_x;
  logic signed [WIDTH:0]   nxt_x;
  dir_t                    dir_nxt;
  logic                    wrap_nxt;
  logic                    unused_msb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q  <= RST_W;
      dir_q  <= UP;
      wrap_q <= 1'b0;
    end else begin
      val_q  <= nxt_x[WIDTH-1:0];
      dir_q  <= dir_nxt;
      wrap_q <= wrap_nxt;
    end
  end

  // All bound checks are signed compares one bit wider than the count, so the
  // native two's-complement rollover can never be taken.
  always_comb begin
    cur_x    = {val_q[WIDTH-1], val_q};
    ld_x     = {bus.ld_val[WIDTH-1], bus.ld_val};
    nxt_x    = cur_x;
    dir_nxt  = dir_q;
    wrap_nxt = 1'b0;
    if (bus.ld) begin
      if (ld_x > MAX_X)      nxt_x = MAX_X;
      else if (ld_x < MIN_X) nxt_x = MIN_X;
      else                   nxt_x = ld_x;
    end else if (bus.en) begin
      case (bus.mode)
        MODE_UP: begin
          if (cur_x < MAX_X) begin
            nxt_x = cur_x + ONE_X;
          end else if (!bus.sat) begin
            nxt_x    = MIN_X;
            wrap_nxt = 1'b1;
          end
        end
        MODE_DOWN: begin
          if (cur_x > MIN_X) begin
            nxt_x = cur_x - ONE_X;
          end else if (!bus.sat) begin
            nxt_x    = MAX_X;
            wrap_nxt = 1'b1;
          end
        end
        MODE_BOUNCE: begin
          // A degenerate single-value range has nowhere to move, so only dir flips.
          if (MIN_X == MAX_X) begin
            dir_nxt = (dir_q == UP) ? DN : UP;
          end else if (dir_q == UP) begin
            if (cur_x < MAX_X) begin
              nxt_x = cur_x + ONE_X;
            end else begin
              nxt_x    = MAX_X - ONE_X;
              dir_nxt  = DN;
              wrap_nxt = 1'b1;
            end
          end else begin
            if (cur_x > MIN_X) begin
              nxt_x = cur_x - ONE_X;
            end else begin
              nxt_x    = MIN_X + ONE_X;
              dir_nxt  = UP;
              wrap_nxt = 1'b1;
            end
          end
        end
        default: begin
          nxt_x = cur_x;
        end
      endcase
    end
  end

  assign unused_msb = nxt_x[WIDTH];

  assign bus.val    = val_q;
  assign bus.dir    = dir_q;
  assign bus.wrap   = wrap_q;
  assign bus.at_max = (val_q == MAX_W);
  assign bus.at_min = (val_q == MIN_W);

endmodule

// File: tb/tb_updown_counter_ctl.sv
// Self-checking bench for updown_counter_ctl with WIDTH=4, bounds [-3,5], reset value 0.
// Directed scenarios use hand-derived sequences; the random run uses an integer reference model.
module tb_updown_counter_ctl;

  localparam int WIDTH = 4;
  localparam int MIN   = -3;
  localparam int MAX   = 5;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  int   m_val;
  bit   m_dir;
  bit   m_wrap;

  updown_counter_ctl_if #(.WIDTH(WIDTH)) bus ();

  updown_counter_ctl #(
    .WIDTH  (WIDTH),
    .MIN_VAL(MIN),
    .MAX_VAL(MAX),
    .RST_VAL(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: integer value and direction updated from the documented rules.
  function automatic void model_step(bit en_i, bit [1:0] mode_i, bit sat_i, bit ld_i, int ldv);
    m_wrap = 1'b0;
    if (ld_i) begin
      m_val = (ldv > MAX) ? MAX : ((ldv < MIN) ? MIN : ldv);
    end else if (en_i) begin
      case (mode_i)
        2'd1: begin
          if (m_val < MAX) m_val = m_val + 1;
          else if (!sat_i) begin m_val = MIN; m_wrap = 1'b1; end
        end
        2'd0: begin
          if (m_val > MIN) m_val = m_val - 1;
          else if (!sat_i) begin m_val = MAX; m_wrap = 1'b1; end
        end
        2'd2: begin
          if (MIN == MAX) m_dir = !m_dir;
          else if (m_dir) begin
            if (m_val < MAX) m_val = m_val + 1;
            else begin m_val = MAX - 1; m_dir = 1'b0; m_wrap = 1'b1; end
          end else begin
            if (m_val > MIN) m_val = m_val - 1;
            else begin m_val = MIN + 1; m_dir = 1'b1; m_wrap = 1'b1; end
          end
        end
        default: m_wrap = 1'b0;
      endcase
    end
  endfunction

  task automatic tick();
    model_step(bus.en, bus.mode, bus.sat, bus.ld, int'(bus.ld_val));
    @(posedge clk);
    #1;
  endtask

  task automatic load_value(int v);
    bus.ld     = 1'b1;
    bus.ld_val = WIDTH'(v);
    tick();
    bus.ld     = 1'b0;
  endtask

  task automatic test_reset();
    bus.en = 1'b0; bus.mode = 2'b11; bus.sat = 1'b0; bus.ld = 1'b0; bus.ld_val = '0;
    rst = 1'b0;
    #2 rst = 1'b1;
    #1;
    m_val = 0; m_dir = 1'b1; m_wrap = 1'b0;
    checks++; if (bus.val !== 4'sd0) begin failures++; $display("FAIL reset_val got=%0d exp=0", bus.val); end
    checks++; if (bus.dir !== 1'b1) begin failures++; $display("FAIL reset_dir got=%b exp=1", bus.dir); end
    checks++; if (bus.wrap !== 1'b0) begin failures++; $display("FAIL reset_wrap got=%b exp=0", bus.wrap); end
    checks++; if (bus.at_min !== 1'b0) begin failures++; $display("FAIL reset_at_min got=%b exp=0", bus.at_min); end
    checks++; if (bus.at_max !== 1'b0) begin failures++; $display("FAIL reset_at_max got=%b exp=0", bus.at_max); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_up_wrap();
    int exp_seq[9] = '{1, 2, 3, 4, 5, -3, -2, -1, 0};
    bus.en = 1'b1; bus.mode = 2'b01; bus.sat = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
      checks++; if (bus.val !== 4'(exp_seq[i])) begin failures++; $display("FAIL up_wrap_val[%0d] got=%0d exp=%0d", i, bus.val, exp_seq[i]); end
      checks++; if (bus.wrap !== (i == 5)) begin failures++; $display("FAIL up_wrap_pulse[%0d] got=%b exp=%b", i, bus.wrap, (i == 5)); end
      checks++; if (bus.at_max !== (exp_seq[i] == 5)) begin failures++; $display("FAIL up_wrap_at_max[%0d] got=%b", i, bus.at_max); end
    end
  endtask

  task automatic test_down_sat();
    int exp_seq[5] = '{-1, -2, -3, -3, -3};
    bus.en = 1'b1; bus.mode = 2'b00; bus.sat = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (bus.val !== 4'(exp_seq[i])) begin failures++; $display("FAIL down_sat_val[%0d] got=%0d exp=%0d", i, bus.val, exp_seq[i]); end
      checks++; if (bus.wrap !== 1'b0) begin failures++; $display("FAIL down_sat_wrap[%0d] got=%b exp=0", i, bus.wrap); end
      checks++; if (bus.at_min !== (i >= 2)) begin failures++; $display("FAIL down_sat_at_min[%0d] got=%b exp=%b", i, bus.at_min, (i >= 2)); end
    end
  endtask

  task automatic test_bounce();
    int exp_val[11] = '{4, 5, 4, 3, 2, 1, 0, -1, -2, -3, -2};
    bit exp_dir[11] = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    bus.en = 1'b1; bus.sat = 1'b0;
    load_value(3);
    bus.mode = 2'b10;
    for (int i = 0; i < 11; i++) begin
      tick();
      checks++; if (bus.val !== 4'(exp_val[i])) begin failures++; $display("FAIL bounce_val[%0d] got=%0d exp=%0d", i, bus.val, exp_val[i]); end
      checks++; if (bus.dir !== exp_dir[i]) begin failures++; $display("FAIL bounce_dir[%0d] got=%b exp=%b", i, bus.dir, exp_dir[i]); end
      checks++; if (bus.wrap !== (i == 2 || i == 10)) begin failures++; $display("FAIL bounce_wrap[%0d] got=%b exp=%b", i, bus.wrap, (i == 2 || i == 10)); end
    end
  endtask

  task automatic test_load_clamp();
    int ld_in[3]  = '{7, -8, 2};
    int ld_exp[3] = '{5, -3, 2};
    bus.en = 1'b1; bus.mode = 2'b01; bus.sat = 1'b0;
    for (int i = 0; i < 3; i++) begin
      load_value(ld_in[i]);
      checks++; if (bus.val !== 4'(ld_exp[i])) begin failures++; $display("FAIL load_clamp_val[%0d] got=%0d exp=%0d", i, bus.val, ld_exp[i]); end
      checks++; if (bus.wrap !== 1'b0) begin failures++; $display("FAIL load_clamp_wrap[%0d] got=%b exp=0", i, bus.wrap); end
      checks++; if (bus.dir !== 1'b1) begin failures++; $display("FAIL load_clamp_dir[%0d] got=%b exp=1", i, bus.dir); end
    end
  endtask

  task automatic test_enable_and_async_reset();
    bit en_seq[3]  = '{1, 0, 1};
    int exp_seq[3] = '{1, 1, 2};
    bus.mode = 2'b01; bus.sat = 1'b0;
    load_value(0);
    for (int i = 0; i < 3; i++) begin
      bus.en = en_seq[i];
      tick();
      checks++; if (bus.val !== 4'(exp_seq[i])) begin failures++; $display("FAIL enable_val[%0d] got=%0d exp=%0d", i, bus.val, exp_seq[i]); end
    end
    bus.en = 1'b1;
    load_value(5);
    bus.mode = 2'b10;
    tick();
    checks++; if (bus.dir !== 1'b0) begin failures++; $display("FAIL pre_reset_dir got=%b exp=0", bus.dir); end
    #3 rst = 1'b1;
    #1;
    m_val = 0; m_dir = 1'b1; m_wrap = 1'b0;
    checks++; if (bus.val !== 4'sd0) begin failures++; $display("FAIL async_reset_val got=%0d exp=0", bus.val); end
    checks++; if (bus.dir !== 1'b1) begin failures++; $display("FAIL async_reset_dir got=%b exp=1", bus.dir); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.en     = ($urandom_range(3) != 0);
      bus.mode   = 2'($urandom_range(3));
      bus.sat    = 1'($urandom_range(1));
      bus.ld     = ($urandom_range(9) == 0);
      bus.ld_val = WIDTH'(int'($urandom_range(15)) - 8);
      tick();
      checks++; if (bus.val !== 4'(m_val)) begin failures++; $display("FAIL random_val[%0d] got=%0d exp=%0d", i, bus.val, m_val); end
      checks++; if (bus.dir !== m_dir) begin failures++; $display("FAIL random_dir[%0d] got=%b exp=%b", i, bus.dir, m_dir); end
      checks++; if (bus.wrap !== m_wrap) begin failures++; $display("FAIL random_wrap[%0d] got=%b exp=%b", i, bus.wrap, m_wrap); end
      checks++; if (bus.at_max !== (m_val == MAX)) begin failures++; $display("FAIL random_at_max[%0d] got=%b", i, bus.at_max); end
      checks++; if (bus.at_min !== (m_val == MIN)) begin failures++; $display("FAIL random_at_min[%0d] got=%b", i, bus.at_min); end
    end
    bus.ld = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_up_wrap();
    test_down_sat();
    test_bounce();
    test_load_clamp();
    test_enable_and_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
